// File: rtl/ex_operand_stage.sv
// ============================================================================
// ex_operand_stage : ID/EX register feeding the ALU, with forwarding and
//                    load-use bubble insertion. Optional macro: EX_STALL_CNT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_operand_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int SEL_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] in_rs,
   input  logic [REG_AW-1:0] in_rt,
   input  logic [DATA_W-1:0] in_rs_data,
   input  logic [DATA_W-1:0] in_rt_data,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_wr,
   input  logic              flush,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_wr,
   input  logic              ex_is_load,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_wr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] Op1,
   output logic [DATA_W-1:0] Op2,
   output logic [SEL_W-1:0]  S_Op,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_wr,
`ifdef EX_STALL_CNT_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic              out_div0
);

   localparam logic [SEL_W-1:0] c_sel_nop = SEL_W'(7);
   localparam logic [SEL_W-1:0] c_sel_div = SEL_W'(3);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] op1_q, op1_d;
   logic [DATA_W-1:0] op2_q, op2_d;
   logic [SEL_W-1:0]  sop_q, sop_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              div0_q, div0_d;

   logic              w_hazard;
   logic              w_slot_free;
   logic              w_in_ready;
   logic [DATA_W-1:0] w_rs_fwd;
   logic [DATA_W-1:0] w_rt_fwd;
   logic [DATA_W-1:0] w_op2;

   // EX result wins over WB; register 0 is hardwired and never forwarded.
   function automatic logic [DATA_W-1:0] fwd(
      input logic [REG_AW-1:0] addr,
      input logic [DATA_W-1:0] rf_data,
      input logic              e_wr,
      input logic              e_load,
      input logic [REG_AW-1:0] e_rd,
      input logic [DATA_W-1:0] e_res,
      input logic              w_wr,
      input logic [REG_AW-1:0] w_rd,
      input logic [DATA_W-1:0] w_dat
   );
      if (addr == '0)
         return rf_data;
      else if (e_wr && !e_load && (e_rd == addr))
         return e_res;
      else if (w_wr && (w_rd == addr))
         return w_dat;
      return rf_data;
   endfunction

   always_comb begin
      w_hazard = in_valid && ex_wr && ex_is_load && (ex_rd != '0) &&
                 ((ex_rd == in_rs) || ((ex_rd == in_rt) && !in_use_imm));
      w_slot_free = !out_valid_q || out_ready;
      w_in_ready  = flush || (w_slot_free && !w_hazard);
      w_rs_fwd = fwd(in_rs, in_rs_data, ex_wr, ex_is_load, ex_rd, ex_result,
                     wb_wr, wb_rd, wb_data);
      w_rt_fwd = fwd(in_rt, in_rt_data, ex_wr, ex_is_load, ex_rd, ex_result,
                     wb_wr, wb_rd, wb_data);
      w_op2 = in_use_imm ? in_imm : w_rt_fwd;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      sop_d       = sop_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      div0_d      = div0_q;
      if (flush) begin
         out_valid_d = 1'b0;
         wr_d        = 1'b0;
         sop_d       = c_sel_nop;
         div0_d      = 1'b0;
      end else if (out_valid_q && !out_ready) begin
         // hold: everything frozen while downstream stalls
      end else if (w_hazard) begin
         out_valid_d = 1'b0;
         wr_d        = 1'b0;
         sop_d       = c_sel_nop;
         div0_d      = 1'b0;
      end else if (in_valid) begin
         out_valid_d = 1'b1;
         op1_d       = w_rs_fwd;
         op2_d       = w_op2;
         sop_d       = in_sel;
         rd_d        = in_rd;
         wr_d        = in_wr;
         div0_d      = (in_sel == c_sel_div) && (w_op2 == '0);
      end else begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         sop_q       <= c_sel_nop;
         rd_q        <= '0;
         wr_q        <= 1'b0;
         div0_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         sop_q       <= sop_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         div0_q      <= div0_d;
      end
   end

`ifdef EX_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (in_valid && !w_in_ready && !flush && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

   assign in_ready  = w_in_ready;
   assign out_valid = out_valid_q;
   assign Op1       = op1_q;
   assign Op2       = op2_q;
   assign S_Op      = sop_q;
   assign out_rd    = rd_q;
   assign out_wr    = wr_q;
   assign out_div0  = div0_q;

endmodule

`default_nettype wire
